cplx_pipe_reg: RTL and testbench
================================

// Module: cplx_pipe_reg
// PURPOSE
//  Parametrised elastic pipeline register for packed complex samples: LANES lanes, each {re,im} of NBITS bits.
//  Real part sits in the upper half of each lane.
//  DEPTH stages with valid/ready handshake, bubble collapsing and synchronous flush.
//  Optional per-sample swap (re<->im) and conjugate, applied on capture, for the IFFT-by-swap trick.
//  Sits between FFT butterfly stages and the twiddle multipliers; replaces fixed single-stage data registers.
// PARAMETERS
//  NBITS  4  bits per real/imag component (two's complement), >=2
//  LANES  1  complex lanes per beat, >=1
//  DEPTH  2  pipeline stages, >=1
// PORTS
//  clk        in   1                rising-edge clock
//  rst_n      in   1                synchronous reset, active low
//  flush      in   1                synchronous clear of all stages
//  in_valid   in   1                input beat valid
//  in_ready   out  1                stage 0 can accept
//  in_data    in   LANES*2*NBITS    lane k at [(k+1)*2*NBITS-1 -: 2*NBITS], {re,im}
//  in_swap    in   1                per-beat mode: exchange re/im of every lane
//  in_conj    in   1                per-beat mode: negate imag of every lane (after swap)
//  out_valid  out  1                = valid of stage DEPTH-1
//  out_ready  in   1                downstream accepts
//  out_data   out  LANES*2*NBITS    data of stage DEPTH-1
//  occ        out  $clog2(DEPTH+1)  number of valid stages
// BEHAVIOUR
//  - One clock, one reset. Reset (rst_n=0 at posedge): all stage valids=0, all stage data=0, occ=0.
//    Hence out_valid=0, out_data=0; in_ready=1 the cycle after reset releases.
//  - Stage k advance: adv[k] = v[k] & (k==DEPTH-1 ? out_ready : (~v[k+1] | adv[k+1])).
//  - Stage k loads: ld[k] = ~v[k] | adv[k]; source is stage k-1, or input for k=0.
//  - in_ready = ld[0]; combinational from out_ready through the chain, no skid.
//  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
//  - No stall: latency DEPTH cycles from input transfer to out_valid; throughput 1 beat/cycle.
//  - Stalled (out_ready=0): stages fill from the output end. Bubbles collapse: an empty stage always loads.
//  - Full (all v=1, out_ready=0): in_ready=0; data held unchanged.
//  - Capture transform, per lane, stage 0 only:
//      r' = swap ? im : re;  i0 = swap ? re : im;  i' = conj ? -i0 : i0.
//    Negation wraps at width NBITS, except -(-2^(NBITS-1)) saturates to 2^(NBITS-1)-1.
//    Later stages copy data unmodified.
//  - occ = popcount(v) after each edge. occ changes by +1, -1 or 0 (simultaneous in/out transfer).
//  - flush=1: all v<=0 next edge; data regs keep their value; an input transfer that cycle is dropped.
//    in_ready still shows ld[0] during flush.
//  - rst_n=0 overrides flush. Reset mid-stream discards all in-flight beats with no partial output.
//  - out_data is stable while out_valid=1 & out_ready=0.
// STRUCTURE
//  - Shared package fft_pkg:
//      cplx_w(NBITS) = 2*NBITS width constant
//      lane slice helpers
//      CPLX_SAT_NEG function (saturating negate)
//  - One sub-module cplx_pipe_stage (valid + data reg, ld/adv logic), instantiated DEPTH times by generate.
//  - Swap/conj logic sits in the top level, ahead of stage 0.
// TESTING
//  All cases NBITS=4, LANES=2, DEPTH=3.
//  1. Reset, then stream 0x12,0x34,0x56 (per lane, out_ready=1, no mode)
//     -> out_valid at cycles 3,4,5; data equal, in order; occ peaks at 3.
//  2. Fill with out_ready=0 for 3 beats
//     -> in_ready=0, occ=3, out_data frozen.
//     Raise out_ready with in_valid=1 -> in_ready=1 the same cycle; occ stays 3; order preserved.
//  3. Lane {re=0x3,im=0x5}, swap=1 -> {0x5,0x3}. conj=1 -> {0x3,0xB}.
//     {re=0x2,im=0x8}, conj=1 -> {0x2,0x7} (saturated).
//  4. Bubbles: in_valid pattern 1,0,1,0 with out_ready=0
//     -> after 4 cycles occ=2, both beats in stages 2 and 1.
//  5. flush while occ=2 and in_valid=1 -> next cycle occ=0, out_valid=0; the flushed-cycle beat never appears.
//  6. rst_n=0 mid-stream with occ=3 -> next cycle out_valid=0, out_data=0, occ=0.
//     Stream resumes correctly after release.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath helpers: complex sample widths, lane slicing and saturating negate.
// Lane helpers work on 32-bit carriers; callers cast to their own widths.
package fft_pkg;

  localparam int MAX_NBITS = 16;

  typedef struct packed {
    logic swap;
    logic conj;
  } cap_mode_t;

  function automatic int cplx_w(input int nbits);
    return 2 * nbits;
  endfunction

  function automatic logic [31:0] comp_mask(input int nbits);
    return (32'd1 << nbits) - 32'd1;
  endfunction

  function automatic logic [31:0] lane_re(input logic [31:0] lane, input int nbits);
    return (lane >> nbits) & comp_mask(nbits);
  endfunction

  function automatic logic [31:0] lane_im(input logic [31:0] lane, input int nbits);
    return lane & comp_mask(nbits);
  endfunction

  function automatic logic [31:0] lane_pack(input logic [31:0] re, input logic [31:0] im,
                                            input int nbits);
    return ((re & comp_mask(nbits)) << nbits) | (im & comp_mask(nbits));
  endfunction

  // The most negative value has no positive twin, so it clamps to the largest positive one.
  function automatic logic [31:0] CPLX_SAT_NEG(input logic [31:0] x, input int nbits);
    logic [31:0] m;
    logic [31:0] most_neg;
    logic [31:0] xm;
    m        = comp_mask(nbits);
    most_neg = 32'd1 << (nbits - 1);
    xm       = x & m;
    if (xm == most_neg)
      return most_neg - 32'd1;
    return (~xm + 32'd1) & m;
  endfunction

endpackage

// File: rtl/cplx_pipe_stage.sv
// One elastic pipeline slot: valid bit plus data register with load/advance control.
module cplx_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         down_ok,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  output logic         v,
  output logic [W-1:0] q
);

  logic adv;
  logic ld;

  assign adv = v & down_ok;
  assign ld  = ~v | adv;

  // Data only moves on a real beat, so an emptied slot keeps its last payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= 1'b0;
      q <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (ld) begin
      v <= src_valid;
      if (src_valid)
        q <= src_data;
    end
  end

endmodule

// File: rtl/cplx_pipe_reg.sv
// Elastic multi-stage register for packed complex lanes, with optional re/im swap
// and conjugate applied as a beat enters the first stage.
module cplx_pipe_reg
  import fft_pkg::*;
#(
  parameter int NBITS = 4,
  parameter int LANES = 1,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*2*NBITS-1:0]     in_data,
  input  logic                         in_swap,
  input  logic                         in_conj,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*2*NBITS-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int CW = cplx_w(NBITS);
  localparam int W  = LANES * CW;
  localparam int OW = $clog2(DEPTH + 1);

  cap_mode_t        mode;
  logic [W-1:0]     cap_data;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] down_ok;
  logic [W-1:0]     q [DEPTH];
  logic [OW-1:0]    occ_c;

  assign mode = '{swap: in_swap, conj: in_conj};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [NBITS-1:0] re;
    logic [NBITS-1:0] im;
    logic [NBITS-1:0] r_out;
    logic [NBITS-1:0] i0;
    logic [NBITS-1:0] i_out;

    assign re    = NBITS'(lane_re(32'(in_data[l*CW +: CW]), NBITS));
    assign im    = NBITS'(lane_im(32'(in_data[l*CW +: CW]), NBITS));
    assign r_out = mode.swap ? im : re;
    assign i0    = mode.swap ? re : im;
    assign i_out = mode.conj ? NBITS'(CPLX_SAT_NEG(32'(i0), NBITS)) : i0;
    assign cap_data[l*CW +: CW] = CW'(lane_pack(32'(r_out), 32'(i_out), NBITS));
  end

  // A slot may hand its beat on when the slot behind it is empty or itself moving.
  always_comb begin
    down_ok = '0;
    down_ok[DEPTH-1] = out_ready;
    for (int k = DEPTH - 2; k >= 0; k--)
      down_ok[k] = ~v[k+1] | down_ok[k+1];
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic         src_valid;
    logic [W-1:0] src_data;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = cap_data;
    end else begin : g_body
      assign src_valid = v[k-1];
      assign src_data  = q[k-1];
    end

    cplx_pipe_stage #(.W(W)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .down_ok   (down_ok[k]),
      .src_valid (src_valid),
      .src_data  (src_data),
      .v         (v[k]),
      .q         (q[k])
    );
  end

  // Same load condition the first stage uses internally.
  assign in_ready  = ~v[0] | down_ok[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = q[DEPTH-1];

  always_comb begin
    occ_c = '0;
    for (int k = 0; k < DEPTH; k++)
      occ_c = occ_c + OW'(v[k]);
  end

  assign occ = occ_c;

endmodule

// File: tb/tb_cplx_pipe_reg.sv
// Scoreboard bench for cplx_pipe_reg: directed scenarios followed by a randomized stream,
// checked against a lane-level arithmetic model and an occupancy count.
module tb_cplx_pipe_reg;

  localparam int NBITS = 4;
  localparam int LANES = 2;
  localparam int DEPTH = 3;
  localparam int W     = LANES * 2 * NBITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_swap = 1'b0;
  logic         in_conj = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occ;

  always #5 clk = ~clk;

  cplx_pipe_reg #(.NBITS(NBITS), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_swap   (in_swap),
    .in_conj   (in_conj),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } beat_t;

  beat_t        sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           model_occ = 0;
  bit           prev_in = 0;
  bit           prev_out = 0;
  bit           prev_rst = 1;
  bit           prev_flush = 0;
  bit           latency_mode = 0;
  bit           use_exp = 0;
  logic [W-1:0] forced_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] satNeg(input logic [3:0] x);
    int s;
    int n;
    s = (x >= 4'd8) ? int'(x) - 16 : int'(x);
    n = -s;
    if (n > 7) n = 7;
    return 4'(n);
  endfunction

  function automatic logic [W-1:0] refModel(input logic [W-1:0] d, input bit sw, input bit cj);
    logic [W-1:0] r;
    logic [3:0]   re;
    logic [3:0]   im;
    logic [3:0]   nr;
    logic [3:0]   ni;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      re = d[l*8+4 +: 4];
      im = d[l*8 +: 4];
      nr = sw ? im : re;
      ni = sw ? re : im;
      if (cj) ni = satNeg(ni);
      r[l*8 +: 8] = {nr, ni};
    end
    return r;
  endfunction

  // One clock of stimulus: check the state the last edge produced, then drive the next inputs.
  task automatic applyStimulus(input bit rstn, input bit fl, input bit iv, input logic [W-1:0] d,
                               input bit sw, input bit cj, input bit ordy);
    beat_t e;
    @(posedge clk);
    #1;
    if (prev_rst || prev_flush) begin
      model_occ = 0;
      checkOutput("valid_cleared", 32'(out_valid), 32'd0);
      if (prev_rst) checkOutput("data_reset", 32'(out_data), 32'd0);
    end else begin
      model_occ = model_occ + int'(prev_in) - int'(prev_out);
    end
    checkOutput("occ", 32'(occ), 32'(model_occ));
    if (out_valid) begin
      if (sb.size() == 0) checkOutput("unexpected_valid", 32'(out_valid), 32'd0);
      else checkOutput("head_data", 32'(out_data), 32'(sb[0].data));
    end

    rst_n     = rstn;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    in_swap   = sw;
    in_conj   = cj;
    out_ready = ordy;
    #2;
    checkOutput("in_ready", 32'(in_ready), 32'(ordy || (model_occ < DEPTH)));
    prev_in = rstn && !fl && iv && in_ready;
    if (!rstn || fl) sb.delete();
    if (prev_in) begin
      e.data = use_exp ? forced_exp : refModel(d, sw, cj);
      e.cyc  = cyc;
      sb.push_back(e);
    end
    prev_rst   = !rstn;
    prev_flush = fl;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && (sb.size() > 0 || model_occ > 0); i++)
      applyStimulus(1, 0, 0, '0, 0, 0, 1);
    applyStimulus(1, 0, 0, '0, 0, 0, 1);
  endtask

  // Monitor: every output transfer pops the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    prev_out = 0;
    if (rst_n && !flush && out_valid && out_ready) begin
      prev_out = 1;
      if (sb.size() == 0) begin
        checkOutput("spurious_beat", 32'(out_data), 32'hDEAD);
      end else begin
        e = sb.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(e.data));
        if (latency_mode) checkOutput("latency", 32'(cyc - e.cyc), 32'(DEPTH));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] rd;
    applyStimulus(0, 0, 0, '0, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 0, 0);

    $display("[TB] streaming three beats");
    latency_mode = 1;
    applyStimulus(1, 0, 1, 16'h1212, 0, 0, 1);
    applyStimulus(1, 0, 1, 16'h3434, 0, 0, 1);
    applyStimulus(1, 0, 1, 16'h5656, 0, 0, 1);
    drain();
    latency_mode = 0;

    $display("[TB] fill under backpressure, then release");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 16'($urandom), 0, 0, 0);
    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 0, 1, 16'hA5C3, 0, 0, 1);
    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    drain();

    $display("[TB] capture transforms");
    use_exp = 1;
    forced_exp = 16'h5353; applyStimulus(1, 0, 1, 16'h3535, 1, 0, 1);
    forced_exp = 16'h3B3B; applyStimulus(1, 0, 1, 16'h3535, 0, 1, 1);
    forced_exp = 16'h2727; applyStimulus(1, 0, 1, 16'h2828, 0, 1, 1);
    forced_exp = 16'h8282; applyStimulus(1, 0, 1, 16'h2828, 1, 0, 1);
    use_exp = 0;
    drain();

    $display("[TB] bubbles collapse under backpressure");
    applyStimulus(1, 0, 1, 16'h1357, 0, 0, 0);
    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 0, 1, 16'h2468, 0, 0, 0);
    applyStimulus(1, 0, 0, '0, 0, 0, 0);

    $display("[TB] flush with a beat offered");
    applyStimulus(1, 1, 1, 16'hEEEE, 0, 0, 0);
    applyStimulus(1, 0, 1, 16'h0F0F, 0, 0, 1);
    applyStimulus(1, 0, 1, 16'h7171, 1, 1, 1);
    drain();

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 16'($urandom), 0, 0, 0);
    applyStimulus(0, 0, 1, 16'h9999, 0, 0, 0);
    applyStimulus(1, 0, 1, 16'h4242, 0, 0, 1);
    applyStimulus(1, 0, 1, 16'h6363, 0, 1, 1);
    drain();

    $display("[TB] randomized stream");
    for (int i = 0; i < 400; i++) begin
      rd = 16'($urandom);
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0),
                    1'($urandom), rd, 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) != 0));
    end
    drain();
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
